// File: rtl/read_ar_issuer.sv
// Splits each even/odd line-pair descriptor into two AXI4 AR bursts, tracks bursts in flight
// against a credit limit, and queues an even/odd tag per burst for the read-data sorter.
module read_ar_issuer #(
   parameter int unsigned ADDR_W          = 32,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned ID_W            = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              desc_valid_i,
   output logic              desc_ready_o,
   input  logic [ADDR_W-1:0] even_addr_i,
   input  logic [ADDR_W-1:0] odd_addr_i,
   input  logic [7:0]        len_i,
   output logic              ar_valid_o,
   input  logic              ar_ready_i,
   output logic [ADDR_W-1:0] ar_addr_o,
   output logic [7:0]        ar_len_o,
   output logic [ID_W-1:0]   ar_id_o,
   output logic [2:0]        ar_size_o,
   output logic [1:0]        ar_burst_o,
   input  logic              r_valid_i,
   input  logic              r_ready_i,
   input  logic              r_last_i,
   output logic              tag_valid_o,
   output logic              tag_o,
   output logic [7:0]        tag_len_o,
   input  logic              tag_ready_i,
   output logic              busy_o,
   output logic              err_o
);

   localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CntW-1:0] CreditMax = CntW'(MAX_OUTSTANDING - 2);
   localparam logic [PtrW-1:0] PtrLast   = PtrW'(MAX_OUTSTANDING - 1);

   typedef enum logic [1:0] {StIdle, StIssueEven, StIssueOdd} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ar_addr_q, odd_addr_q;
   logic [7:0]        ar_len_q;
   logic [CntW-1:0]   outst_q, outst_d;
   logic              err_q, err_d;
   logic [CntW-1:0]   fifo_cnt_q;
   logic [PtrW-1:0]   wptr_q, rptr_q;
   logic              tag_mem_q [MAX_OUTSTANDING];
   logic [7:0]        len_mem_q [MAX_OUTSTANDING];
   logic              ar_is_odd;
   logic              desc_hs, ar_hs, r_last_hs, push, pop;

   assign desc_hs   = desc_valid_i & desc_ready_o;
   assign ar_hs     = ar_valid_o & ar_ready_i;
   assign r_last_hs = r_valid_i & r_ready_i & r_last_i;
   assign push      = ar_hs;
   assign pop       = tag_valid_o & tag_ready_i;

   // FSM: state register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:      if (desc_hs) state_d = StIssueEven;
         StIssueEven: if (ar_ready_i) state_d = StIssueOdd;
         StIssueOdd:  if (ar_ready_i) state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   // FSM: outputs; both credit and tag-slot checks must leave room for a full pair
   always_comb begin
      ar_valid_o   = (state_q == StIssueEven) || (state_q == StIssueOdd);
      ar_is_odd    = (state_q == StIssueOdd);
      desc_ready_o = (state_q == StIdle) && (outst_q <= CreditMax) && (fifo_cnt_q <= CreditMax);
      busy_o       = (state_q != StIdle) || (outst_q != '0);
   end

   // AR payload registers; the odd address is swapped in once the even burst is taken
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ar_addr_q  <= '0;
         odd_addr_q <= '0;
         ar_len_q   <= '0;
      end else if (desc_hs) begin
         ar_addr_q  <= even_addr_i;
         odd_addr_q <= odd_addr_i;
         ar_len_q   <= len_i;
      end else if (ar_hs && (state_q == StIssueEven)) begin
         ar_addr_q <= odd_addr_q;
      end
   end

   assign ar_addr_o  = ar_addr_q;
   assign ar_len_o   = ar_len_q;
   assign ar_id_o    = ID_W'(ar_is_odd);
   assign ar_size_o  = 3'($clog2(DATA_W / 8));
   assign ar_burst_o = 2'b01;

   // Outstanding-burst credit counter; a stray R last never underflows, it flags an error
   always_comb begin
      outst_d = outst_q;
      err_d   = err_q;
      if (r_last_hs && (outst_q == '0)) err_d = 1'b1;
      if (ar_hs && !r_last_hs) begin
         outst_d = outst_q + CntW'(1);
      end else if (!ar_hs && r_last_hs && (outst_q != '0)) begin
         outst_d = outst_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         outst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         outst_q <= outst_d;
         err_q   <= err_d;
      end
   end

   assign err_o = err_q;

   // Tag FIFO control
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) wptr_q <= (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
         if (pop)  rptr_q <= (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
         if (push && !pop) begin
            fifo_cnt_q <= fifo_cnt_q + CntW'(1);
         end else if (!push && pop) begin
            fifo_cnt_q <= fifo_cnt_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         tag_mem_q[wptr_q] <= ar_is_odd;
         len_mem_q[wptr_q] <= ar_len_q;
      end
   end

   // Storage is unreset, so outputs are masked while empty
   assign tag_valid_o = (fifo_cnt_q != '0);
   assign tag_o       = tag_valid_o ? tag_mem_q[rptr_q] : 1'b0;
   assign tag_len_o   = tag_valid_o ? len_mem_q[rptr_q] : 8'h00;

endmodule

// File: tb/tb_read_ar_issuer.sv
// Bench for read_ar_issuer: directed scenarios plus random traffic, all checked every cycle
// against a queue-based transaction model.
module tb_read_ar_issuer;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned MAX_OUT = 4;
   localparam int unsigned ID_W    = 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              desc_valid, desc_ready;
   logic [ADDR_W-1:0] even_addr, odd_addr;
   logic [7:0]        len;
   logic              ar_valid, ar_ready;
   logic [ADDR_W-1:0] ar_addr;
   logic [7:0]        ar_len;
   logic [ID_W-1:0]   ar_id;
   logic [2:0]        ar_size;
   logic [1:0]        ar_burst;
   logic              r_valid, r_ready, r_last;
   logic              tag_valid, tag;
   logic [7:0]        tag_len;
   logic              tag_ready;
   logic              busy, err;

   always #5 clk = ~clk;

   read_ar_issuer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT), .ID_W(ID_W)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
      .even_addr_i(even_addr), .odd_addr_i(odd_addr), .len_i(len),
      .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
      .ar_len_o(ar_len), .ar_id_o(ar_id), .ar_size_o(ar_size), .ar_burst_o(ar_burst),
      .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
      .tag_valid_o(tag_valid), .tag_o(tag), .tag_len_o(tag_len), .tag_ready_i(tag_ready),
      .busy_o(busy), .err_o(err)
   );

   // Reference model: pending AR bursts, tag queue, bursts in flight, sticky error
   typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] len; logic id; } ar_t;
   typedef struct { logic tag; logic [7:0] len; } tg_t;
   ar_t arq[$];
   tg_t tagq[$];
   int  outst = 0;
   bit  m_err = 1'b0;
   int  n_checks = 0;
   int  n_fail = 0;

   task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return (arq.size() == 0) && (outst <= int'(MAX_OUT) - 2) &&
             (int'(MAX_OUT) - tagq.size() >= 2);
   endfunction

   task automatic compare_outputs();
      check_eq("desc_ready", desc_ready, m_ready());
      check_eq("ar_valid", ar_valid, arq.size() != 0);
      if (arq.size() != 0) begin
         check_eq("ar_addr", ar_addr, arq[0].addr);
         check_eq("ar_len", ar_len, arq[0].len);
         check_eq("ar_id", ar_id, arq[0].id);
      end
      check_eq("tag_valid", tag_valid, tagq.size() != 0);
      if (tagq.size() != 0) begin
         check_eq("tag", tag, tagq[0].tag);
         check_eq("tag_len", tag_len, tagq[0].len);
      end
      check_eq("busy", busy, (arq.size() != 0) || (outst != 0));
      check_eq("err", err, m_err);
   endtask

   task automatic model_update();
      bit acc, hs, rl, pop;
      if (!rst_n) begin
         arq.delete();
         tagq.delete();
         outst = 0;
         m_err = 1'b0;
         return;
      end
      acc = desc_valid && m_ready();
      hs  = (arq.size() != 0) && ar_ready;
      rl  = r_valid && r_ready && r_last;
      pop = (tagq.size() != 0) && tag_ready;
      if (pop) void'(tagq.pop_front());
      if (hs) begin
         tagq.push_back('{tag: arq[0].id, len: arq[0].len});
         void'(arq.pop_front());
      end
      if (rl && outst == 0) m_err = 1'b1;
      if (hs && !rl) outst++;
      else if (!hs && rl && outst > 0) outst--;
      if (acc) begin
         arq.push_back('{addr: even_addr, len: len, id: 1'b0});
         arq.push_back('{addr: odd_addr, len: len, id: 1'b1});
      end
   endtask

   // Inputs are set by the caller before step; outputs are checked at the falling edge
   task automatic step();
      @(negedge clk);
      compare_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      desc_valid = 1'b0; ar_ready = 1'b0; tag_ready = 1'b0;
      r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
   endtask

   task automatic rlast_pulse();
      r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1;
      step();
      r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
   endtask

   task automatic drain();
      desc_valid = 1'b0; ar_ready = 1'b1; tag_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         r_valid = (outst > 0); r_ready = 1'b1; r_last = (outst > 0);
         step();
      end
      r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
   endtask

   task automatic set_desc(input logic [ADDR_W-1:0] e, input logic [ADDR_W-1:0] o,
                           input logic [7:0] l);
      even_addr = e; odd_addr = o; len = l; desc_valid = 1'b1;
   endtask

   initial begin
      idle_inputs();
      even_addr = '0; odd_addr = '0; len = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ar_valid", ar_valid, 0);
      check_eq("rst_ar_addr", ar_addr, 0);
      check_eq("rst_ar_len", ar_len, 0);
      check_eq("rst_ar_id", ar_id, 0);
      check_eq("rst_tag_valid", tag_valid, 0);
      check_eq("rst_tag", tag, 0);
      check_eq("rst_tag_len", tag_len, 0);
      check_eq("rst_desc_ready", desc_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_err", err, 0);
      check_eq("ar_size", ar_size, $clog2(DATA_W / 8));
      check_eq("ar_burst", ar_burst, 2'b01);
      rst_n = 1'b1;

      // Single descriptor, AR always ready
      ar_ready = 1'b1;
      set_desc(32'h1000, 32'h1400, 8'd15);
      step();
      desc_valid = 1'b0;
      check_eq("t1_even_addr", ar_addr, 32'h1000);
      check_eq("t1_even_id", ar_id, 0);
      check_eq("t1_even_len", ar_len, 15);
      step();
      check_eq("t1_odd_addr", ar_addr, 32'h1400);
      check_eq("t1_odd_id", ar_id, 1);
      step();
      check_eq("t1_idle_ready", desc_ready, 1);
      check_eq("t1_tag0", tag, 0);
      check_eq("t1_tag0_len", tag_len, 15);
      tag_ready = 1'b1;
      step();
      check_eq("t1_tag1", tag, 1);
      check_eq("t1_tag1_len", tag_len, 15);
      step();
      tag_ready = 1'b0;
      check_eq("t1_busy_inflight", busy, 1);
      rlast_pulse();
      check_eq("t1_busy_one_left", busy, 1);
      rlast_pulse();
      check_eq("t1_busy_done", busy, 0);

      // AR backpressure during the even burst
      ar_ready = 1'b0;
      set_desc(32'hA000, 32'hB000, 8'd7);
      step();
      desc_valid = 1'b0;
      repeat (5) step();
      ar_ready = 1'b1;
      repeat (3) step();
      drain();

      // Credit stall with no R lasts
      ar_ready = 1'b1; tag_ready = 1'b1;
      set_desc(32'h2000, 32'h2400, 8'd3);
      repeat (10) step();
      check_eq("t3_stalled", desc_ready, 0);
      desc_valid = 1'b0;
      rlast_pulse();
      check_eq("t3_still_stalled", desc_ready, 0);
      rlast_pulse();
      check_eq("t3_resumed", desc_ready, 1);
      drain();

      // AR handshake and R last in the same cycle at two in flight
      ar_ready = 1'b1; tag_ready = 1'b1;
      set_desc(32'h3000, 32'h3400, 8'd1);
      step();
      desc_valid = 1'b0;
      step(); step();
      set_desc(32'h3800, 32'h3C00, 8'd2);
      step();
      desc_valid = 1'b0;
      rlast_pulse();
      step();
      drain();

      // Tag FIFO full blocks acceptance even with no bursts in flight
      ar_ready = 1'b1; tag_ready = 1'b0;
      set_desc(32'h4000, 32'h4400, 8'd4);
      repeat (8) step();
      repeat (4) rlast_pulse();
      step();
      check_eq("t5_fifo_full_stall", desc_ready, 0);
      desc_valid = 1'b0;
      tag_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("t5_tag_order", tag, i % 2);
         step();
         if (i == 1) check_eq("t5_ready_after_pops", desc_ready, 1);
      end
      drain();

      // Random traffic with rare resets; stray R lasts avoided so err stays meaningful
      for (int c = 0; c < 1500; c++) begin
         rst_n      = ($urandom_range(0, 299) != 0);
         desc_valid = $urandom_range(0, 1);
         even_addr  = $urandom;
         odd_addr   = $urandom;
         len        = 8'($urandom);
         ar_ready   = ($urandom_range(0, 3) != 0);
         tag_ready  = ($urandom_range(0, 2) != 0);
         r_valid    = $urandom_range(0, 1);
         r_ready    = ($urandom_range(0, 3) != 0);
         r_last     = (outst > 0) && ($urandom_range(0, 2) == 0);
         step();
      end
      rst_n = 1'b1;
      drain();

      // Reset during the odd burst, then a stray R last sets the sticky error
      idle_inputs();
      ar_ready = 1'b1;
      set_desc(32'h5000, 32'h5400, 8'd9);
      step();
      desc_valid = 1'b0;
      step();
      ar_ready = 1'b0;
      check_eq("t6_in_odd", ar_id, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_eq("t6_ar_valid", ar_valid, 0);
      check_eq("t6_tag_valid", tag_valid, 0);
      check_eq("t6_busy", busy, 0);
      check_eq("t6_desc_ready", desc_ready, 1);
      rlast_pulse();
      check_eq("t6_err_set", err, 1);
      repeat (3) step();
      check_eq("t6_err_sticky", err, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_eq("t6_err_cleared", err, 0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
